// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer:
// op encodings, sequencer states, UART register defaults, byte-select patterns.
package mem_bus_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [31:0] UART_DATA_ADDR_DEF = 32'hBFD003F8;
  localparam logic [31:0] UART_STAT_ADDR_DEF = 32'hBFD003FC;

  // Active-low byte selects
  localparam logic [3:0] SEL_NONE    = 4'b1111;
  localparam logic [3:0] SEL_WORD    = 4'b0000;
  localparam logic [3:0] SEL_HALF_LO = 4'b1100;
  localparam logic [3:0] SEL_HALF_HI = 4'b0011;
  localparam logic [3:0] SEL_UART    = 4'b1110;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfwords need addr[0] clear, words need addr[1:0] clear
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      OP_LW, OP_SW:         bad = |lo;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte selects, store-data replication and
// load-data alignment with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic        uart,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // Select lanes and build store/load data for the current op
  always_comb begin
    sel_n     = SEL_WORD;
    wdata_rep = wdata;
    rdata_ext = rdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    b         = rdata[7:0];
    h         = rdata[15:0];
    if (uart) begin
      // UART registers are byte-wide on lane 0 regardless of op size
      sel_n     = SEL_UART;
      wdata_rep = {4{wdata[7:0]}};
      rdata_ext = (op == OP_LB) ? {{24{b[7]}}, b} : {24'b0, b};
    end else begin
      case (op)
        OP_LB, OP_LBU, OP_SB: begin
          sel_n     = ~(4'b0001 << addr_lo);
          wdata_rep = {4{wdata[7:0]}};
          b         = shifted[7:0];
          rdata_ext = (op == OP_LB) ? {{24{b[7]}}, b} : {24'b0, b};
        end
        OP_LH, OP_LHU, OP_SH: begin
          sel_n     = addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
          wdata_rep = {2{wdata[15:0]}};
          h         = addr_lo[1] ? rdata[31:16] : rdata[15:0];
          rdata_ext = (op == OP_LH) ? {{16{h[15]}}, h} : {16'b0, h};
        end
        default: begin
          sel_n     = SEL_WORD;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store sequencer: IDLE -> SETUP -> ACCESS(xWAIT_CYCLES) -> DONE.
// Optional saturating stall-cycle counter enabled by MEM_BUS_PERF_CNT_EN.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [31:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        ram_ce_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_we_n_o,
  output logic [3:0]  ram_sel_n_o,
  input  logic [31:0] ram_data_i,
  output logic [31:0] stall_cycles_o
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic        misaligned, accept, is_uart, store_q;
  logic [3:0]  sel_n;
  logic [31:0] wdata_rep, rdata_ext;

  assign misaligned = op_misaligned(req_op, req_addr[1:0]);
  assign accept     = (state == IDLE) && req_valid && !misaligned;
  assign is_uart    = (addr_q == UART_DATA_ADDR) || (addr_q == UART_STAT_ADDR);
  assign store_q    = op_is_store(op_q);

  // Lanes are derived from the latched request so they hold for the whole transaction
  mem_lane_align u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .uart      (is_uart),
    .wdata     (wdata_q),
    .rdata     (ram_data_i),
    .sel_n     (sel_n),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: single pass, no DONE->SETUP shortcut
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (wait_cnt == WAIT_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture the request on acceptance; held until the next accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // ACCESS dwell counter
  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 4'd1;
  end

  // Response and error pulses; resp_valid accompanies the freshly registered load data
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      addr_err   <= 1'b0;
    end else begin
      resp_valid <= (state == DONE);
      addr_err   <= (state == IDLE) && req_valid && misaligned;
      if (state == DONE && !store_q) resp_rdata <= rdata_ext;
    end
  end

  // Bus drive and pipeline stall; address/data/sel only move in IDLE, so they are stable under we_n
  always_comb begin
    stall_o     = accept || (state == SETUP) || (state == ACCESS);
    ram_ce_o    = (state != IDLE);
    ram_we_n_o  = !((state == ACCESS) && store_q);
    ram_sel_n_o = ram_ce_o ? sel_n : SEL_NONE;
    ram_addr_o  = {addr_q[31:2], 2'b00};
    ram_data_o  = wdata_rep;
  end

`ifdef MEM_BUS_PERF_CNT_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst)                                 stall_cycles_o <= '0;
    else if (stall_o && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
  end
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Load/store sequencer between the CPU MEM stage and the address-mapping RAM block.
- Turns one MEM-stage request (LB/LBU/LH/LHU/LW/SB/SH/SW) into a multi-cycle SRAM-safe bus transaction.
- Generates active-low byte selects, aligns load data and sign-extends it, and stalls the pipeline for the full duration of the transaction.
- Addresses are physical: BaseRAM 0x80000000–0x803FFFFF, ExtRAM 0x80400000–0x807FFFFF, UART data 0xBFD003F8, UART status 0xBFD003FC.

Parameters:
- WAIT_CYCLES, 1: cycles the ACCESS state is held (SRAM access/write-pulse width); legal range 1–15.
- UART_DATA_ADDR, 32'hBFD003F8: UART data register address.
- UART_STAT_ADDR, 32'hBFD003FC: UART status register address.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset
- req_valid  in  1  MEM stage has a memory op this cycle
- req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall_o  out  1  freeze pipeline
- resp_valid  out  1  one-cycle pulse: transaction done
- resp_rdata  out  32  aligned, extended load data
- addr_err  out  1  one-cycle pulse on misaligned request
- ram_ce_o  out  1  bus request active
- ram_addr_o  out  32  word-aligned address (bits [1:0] forced to 0)
- ram_data_o  out  32  lane-replicated store data
- ram_we_n_o  out  1  write enable, active low
- ram_sel_n_o  out  4  byte enables, active low
- ram_data_i  in  32  read data from the RAM mapping block
- stall_cycles_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - state = IDLE.
  - ram_ce_o = 0, ram_we_n_o = 1, ram_sel_n_o = 4'b1111.
  - ram_addr_o = 0, ram_data_o = 0.
  - resp_valid = 0, resp_rdata = 0, addr_err = 0, stall_o = 0, stall_cycles_o = 0.
- Alignment rules:
  - Halfword ops need addr[0] = 0; word ops need addr[1:0] = 0.
  - A misaligned request pulses addr_err for 1 cycle, issues no bus cycle, does not stall, and stays in IDLE.
- Lanes are little-endian:
  - Byte at addr[1:0] = n → sel_n bit n low.
  - Halfword at addr[1] = h → sel_n = h ? 4'b0011 : 4'b1100.
  - Word → 4'b0000.
  - Store data replicated: byte ×4, halfword ×2.
  - UART addresses always use sel_n 4'b1110, with the byte on lane 0.
- FSM:
  - IDLE: on aligned req_valid, latch op/addr/data and go to SETUP.
  - SETUP (1 cycle): ce = 1, address/sel/data driven, we_n = 1 → ACCESS.
  - ACCESS (WAIT_CYCLES cycles): we_n = 0 for stores, 1 for loads; address/data/sel held stable → DONE.
  - DONE (1 cycle): we_n = 1, ce = 1. Register ram_data_i lane-aligned into resp_rdata (loads only; stores leave it unchanged). Pulse resp_valid → IDLE.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend. UART status returns bits [1:0] unchanged.
- stall_o timing:
  - Combinational: asserted in IDLE when an aligned req_valid is present, and in SETUP/ACCESS.
  - Deasserted in DONE, so the pipeline advances on the same edge that resp_rdata becomes valid.
  - Total stall per access = WAIT_CYCLES + 2 cycles.
- req_valid is ignored outside IDLE; the MEM stage is frozen by stall_o.
- Address/data/sel never change while we_n = 0. we_n rises one cycle before address changes (write hold).
- Reset mid-transaction: the next edge forces IDLE with we_n = 1 and ce = 0. A partially completed store is undefined in memory, but no further write occurs.
- Back-to-back requests: after DONE, a new request is accepted from IDLE on the following cycle; there is no combined DONE→SETUP path.

Optional Feature:
- MEM_BUS_PERF_CNT_EN defined: stall_cycles_o is a saturating 32-bit counter.
  - Increments every cycle stall_o = 1.
  - Holds at 32'hFFFFFFFF once saturated.
  - Cleared only by rst.
- Undefined: stall_cycles_o is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package mem_bus_pkg holds:
  - op encoding constants (OP_LB…OP_SW);
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - UART address defaults;
  - sel_n patterns.
- Sub-module mem_lane_align is purely combinational:
  - computes sel_n, replicated store data, and extended load data from op and addr[1:0];
  - is instantiated once.

Test Plan:
- SW addr 0x80400004, data 0xDEADBEEF, WAIT_CYCLES = 1:
  - SETUP → ACCESS → DONE; we_n low for exactly 1 cycle.
  - ram_addr_o 0x80400004, sel_n 0000; stall high for 3 cycles; resp_valid pulses in cycle 3.
- LB addr 0x80400006, ram_data_i 0x12F45678:
  - sel_n 1011; resp_rdata 0xFFFFFFF4.
  - Same access with LBU → 0x000000F4.
- SH addr 0x80000002, data 0x0000ABCD:
  - ram_data_o 0xABCDABCD, sel_n 0011, we_n = 0 only in ACCESS.
- LW addr 0x80000001:
  - addr_err = 1 for 1 cycle, ce stays 0, stall_o stays 0, no resp_valid.
- Reset mid-transaction: rst asserted during ACCESS of an SW.
  - Next cycle: we_n = 1, ce = 0, state IDLE, stall_o = 0.
  - A following LW to UART_STAT_ADDR (ram_data_i 0x3) returns 0x00000003 with sel_n 1110.
- With MEM_BUS_PERF_CNT_EN, WAIT_CYCLES = 3, two loads:
  - stall_cycles_o = 10; addr_err requests add 0.
